// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit. The carry chain is split into STAGES chunks,
// one per stage, and a single global advance enable moves or holds the whole pipe.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_b  [STAGES];
    logic [WIDTH-1:0] part  [STAGES];
    logic             carry [STAGES];
    logic             vld   [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign op_a[0]  = a;
    assign op_b[0]  = sub ? ~b : b;
    assign part[0]  = '0;
    assign carry[0] = sub ? ~cin : cin;
    assign vld[0]   = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] part_next;

        assign chunk = {1'b0, op_a[k][CW-1:0]} + {1'b0, op_b[k][CW-1:0]}
                     + {{CW{1'b0}}, carry[k]};
        // Finished chunks enter at the top and slide down one chunk per stage,
        // so after the last stage chunk 0 sits at bit 0.
        assign part_next = (part[k] >> CW) | (WIDTH'(chunk[CW-1:0]) << (WIDTH - CW));

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] part_q;
            logic             carry_q;
            logic             vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    part_q  <= '0;
                    carry_q <= 1'b0;
                    vld_q   <= 1'b0;
                end else if (adv) begin
                    a_q     <= op_a[k] >> CW;
                    b_q     <= op_b[k] >> CW;
                    part_q  <= part_next;
                    carry_q <= chunk[CW];
                    vld_q   <= vld[k];
                end
            end

            assign op_a[k+1]  = a_q;
            assign op_b[k+1]  = b_q;
            assign part[k+1]  = part_q;
            assign carry[k+1] = carry_q;
            assign vld[k+1]   = vld_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum_q;
            logic             cout_q;
            logic             ovf_q;
            logic             vld_q;
            logic             msb_a;
            logic             msb_b;

            // The top chunk of the shifted operands carries the operand sign bits.
            assign msb_a = op_a[k][CW-1];
            assign msb_b = op_b[k][CW-1];

            // Result registers load only on valid data so bubbles never disturb them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    vld_q  <= 1'b0;
                end else if (adv) begin
                    vld_q <= vld[k];
                    if (vld[k]) begin
                        sum_q  <= part_next;
                        cout_q <= chunk[CW];
                        ovf_q  <= (msb_a == msb_b) && (chunk[CW-1] != msb_a);
                    end
                end
            end

            assign sum       = sum_q;
            assign cout      = cout_q;
            assign ovf       = ovf_q;
            assign out_valid = vld_q;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4) with directed cases,
// random streams, backpressure and asynchronous reset, against an arithmetic model.
module tb_pipe_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          got_t[$];

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        int  ures;
        int  sres;
        logic c;
        logic o;
        if (!sb) begin
            ures = int'(x) + int'(y) + int'(ci);
            sres = int'($signed(x)) + int'($signed(y)) + int'(ci);
            c    = (ures >= 65536);
        end else begin
            ures = int'(x) - int'(y) - int'(ci);
            sres = int'($signed(x)) - int'($signed(y)) - int'(ci);
            c    = (ures >= 0);
        end
        o = (sres > 32767) || (sres < -32768);
        return {o, c, 16'(ures)};
    endfunction

    // Drives one cycle at the falling edge and records accepts and retirements
    // that the following rising edge will perform.
    task automatic drive_cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                               input logic ic, input logic is, input logic ordy,
                               output logic rdy_seen);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        ncyc++;
        rdy_seen = in_ready;
        if (in_valid && in_ready) exp_q.push_back(model(ia, ib, ic, is));
        if (out_valid && out_ready) begin
            got_q.push_back({ovf, cout, sum});
            got_t.push_back(ncyc);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({ovf, cout, sum} !== 18'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ovf, cout, sum});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [15:0] ia, input logic [15:0] ib,
                               input logic ic, input logic is, input logic [15:0] e_sum,
                               input logic e_cout, input logic e_ovf);
        logic rdy;
        clear_queues();
        drive_cycle(1'b1, ia, ib, ic, is, 1'b1, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("FAIL %s_accept: got in_ready %b expected 1", name, rdy);
        end
        for (int i = 1; i < S; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s_early_valid: cycle %0d got %b expected 0", name, i, out_valid);
            end
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_latency: got out_valid %b expected 1", name, out_valid);
        end
        n_checks++;
        if (sum !== e_sum) begin
            n_fail++; $display("FAIL %s_sum: got %h expected %h", name, sum, e_sum);
        end
        n_checks++;
        if (cout !== e_cout) begin
            n_fail++; $display("FAIL %s_cout: got %b expected %b", name, cout, e_cout);
        end
        n_checks++;
        if (ovf !== e_ovf) begin
            n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, e_ovf);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_retired: got out_valid %b expected 0", name, out_valid);
        end
        n_checks++;
        if ({ovf, cout, sum} !== {e_ovf, e_cout, e_sum}) begin
            n_fail++; $display("FAIL %s_hold_last: got %h expected %h", name, {ovf, cout, sum}, {e_ovf, e_cout, e_sum});
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        int   t0;
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, rdy);
            if (i == 0) t0 = ncyc;
            n_checks++;
            if (rdy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready: op %0d got %b expected 1", i, rdy);
            end
        end
        for (int i = 0; i < 20 && got_q.size() < 8; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (got_q.size() !== 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected 8", got_q.size());
        end else begin
            n_checks++;
            if (got_t[0] !== t0 + S) begin
                n_fail++; $display("FAIL b2b_latency: got cycle %0d expected %0d", got_t[0], t0 + S);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL b2b_result: op %0d got %h expected %h", i, got_q[i], exp_q[i]);
                end
                n_checks++;
                if (got_t[i] !== got_t[0] + i) begin
                    n_fail++; $display("FAIL b2b_spacing: op %0d got cycle %0d expected %0d", i, got_t[i], got_t[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        clear_queues();
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, rdy);
        for (int s = 0; s < 3; s++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, rdy);
            n_checks++;
            if (rdy !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: stall %0d got %b expected 0", s, rdy);
            end
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_out_valid: stall %0d got %b expected 1", s, out_valid);
            end
            n_checks++;
            if ({ovf, cout, sum} !== exp_q[0]) begin
                n_fail++; $display("FAIL bp_hold: stall %0d got %h expected %h", s, {ovf, cout, sum}, exp_q[0]);
            end
        end
        for (int i = 0; i < 4; i++)
            drive_cycle(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, rdy);
        for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d results expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_result: op %0d got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic rdy;
        int   mism;
        clear_queues();
        for (int i = 0; i < 80; i++)
            drive_cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                        1'($urandom), $urandom_range(0, 3) != 0, rdy);
        for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d results expected %0d", got_q.size(), exp_q.size());
        end else begin
            mism = 0;
            for (int i = 0; i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    if (mism < 5) $display("FAIL rand_result: op %0d got %h expected %h", i, got_q[i], exp_q[i]);
                    mism++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic rdy;
        clear_queues();
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b1, 16'($urandom) | 16'h0100, 16'($urandom), 1'($urandom), 1'b0, 1'b1, rdy);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({ovf, cout, sum} !== 18'h0) begin
            n_fail++; $display("FAIL mid_rst_outputs: got %h expected 0", {ovf, cout, sum});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL mid_rst_stale: got %0d results expected 0", got_q.size());
        end
        test_single("post_rst", 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single("add_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        test_single("ripple",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_single("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_single("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_single("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
